// File: rtl/pdn_drain_pkg.sv
// rtl/pdn_drain_pkg.sv - shared geometry, state type and address helper for the output drain
package pdn_drain_pkg;

    localparam int LANES          = 256;
    localparam int SLOTS          = 16;
    localparam int DATA_W         = 32;
    localparam int BEAT_LANES     = 8;
    localparam int BEATS_PER_SLOT = LANES / BEAT_LANES;
    localparam int ADDR_W         = 32;
    localparam int IDX_W          = $clog2(SLOTS);
    localparam int BEAT_W         = $clog2(BEATS_PER_SLOT);
    localparam int CNT_W          = IDX_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        SEND,
        FIN
    } drain_state_e;

    function automatic logic [ADDR_W-1:0] lane_to_byte(input logic [ADDR_W-1:0] lanes);
        return lanes << 2;
    endfunction

endpackage

// File: rtl/drain_beat_mux.sv
// rtl/drain_beat_mux.sv - registered 32:1 beat selector from the captured slot to mem_data
module drain_beat_mux
    import pdn_drain_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load,
    input  logic [LANES*DATA_W-1:0]       slot_data,
    input  logic [BEAT_W-1:0]             beat,
    output logic [BEAT_LANES*DATA_W-1:0]  beat_data
);

    localparam int BEAT_BITS = BEAT_LANES * DATA_W;

    logic [BEAT_BITS-1:0] data_d;
    logic [BEAT_BITS-1:0] data_q;

    // Holding when not loaded keeps mem_data stable through stalls and idle time.
    always_comb begin
        data_d = data_q;
        if (load) begin
            for (int i = 0; i < BEATS_PER_SLOT; i++) begin
                if (beat == BEAT_W'(i)) begin
                    data_d = slot_data[i*BEAT_BITS +: BEAT_BITS];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign beat_data = data_q;

endmodule

// File: rtl/output_drain.sv
// rtl/output_drain.sv - drains a run of output-buffer slots to memory as 32 beats per slot
module output_drain
    import pdn_drain_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [ADDR_W-1:0]             base_addr,
    input  logic [IDX_W-1:0]              slot_first,
    input  logic [CNT_W-1:0]              slot_count,
    output logic                          busy,
    output logic                          done,
    output logic [IDX_W-1:0]              ob_idx,
    output logic                          ob_read_en,
    input  logic [LANES*DATA_W-1:0]       ob_out,
    output logic                          mem_valid,
    input  logic                          mem_ready,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [BEAT_LANES*DATA_W-1:0]  mem_data,
    output logic                          mem_last
);

    localparam logic [ADDR_W-1:0] BEAT_STRIDE = lane_to_byte(ADDR_W'(BEAT_LANES));
    localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BEATS_PER_SLOT - 1);

    drain_state_e            state_d, state_q;
    logic [IDX_W-1:0]        first_d, first_q;
    logic [CNT_W-1:0]        count_d, count_q;
    logic [CNT_W-1:0]        n_d, n_q;
    logic [BEAT_W-1:0]       b_d, b_q;
    logic [ADDR_W-1:0]       addr_d, addr_q;
    logic                    busy_d, busy_q;
    logic                    done_d, done_q;
    logic                    rd_d, rd_q;
    logic [IDX_W-1:0]        idx_d, idx_q;
    logic                    valid_d, valid_q;
    logic                    last_d, last_q;
    logic [LANES*DATA_W-1:0] slot_d, slot_q;

    always_comb begin
        state_d = state_q;
        first_d = first_q;
        count_d = count_q;
        n_d     = n_q;
        b_d     = b_q;
        addr_d  = addr_q;
        slot_d  = slot_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (slot_count == '0) begin
                        state_d = FIN;
                    end else begin
                        first_d = slot_first;
                        count_d = slot_count;
                        n_d     = '0;
                        b_d     = '0;
                        addr_d  = base_addr;
                        state_d = RD;
                    end
                end
            end
            RD:  state_d = CAP;
            CAP: begin
                slot_d  = ob_out;
                state_d = SEND;
            end
            SEND: begin
                // Slots are laid out back to back, so a running pointer equals base + offset.
                if (mem_ready) begin
                    addr_d = addr_q + BEAT_STRIDE;
                    if (b_q == LAST_BEAT) begin
                        b_d     = '0;
                        n_d     = n_q + 1'b1;
                        state_d = (n_q + 1'b1 == count_q) ? FIN : RD;
                    end else begin
                        b_d = b_q + 1'b1;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == FIN);
        rd_d    = (state_d == RD);
        idx_d   = rd_d ? first_d + n_d[IDX_W-1:0] : idx_q;
        valid_d = (state_d == SEND);
        last_d  = valid_d && (b_d == LAST_BEAT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            first_q <= '0;
            count_q <= '0;
            n_q     <= '0;
            b_q     <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= 1'b0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            count_q <= count_d;
            n_q     <= n_d;
            b_q     <= b_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rd_q    <= rd_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        slot_q <= slot_d;
    end

    // Fed with next-cycle slot and beat so the first beat is ready right after CAP.
    drain_beat_mux u_beat_mux (
        .clk       (clk),
        .rst_n     (rst),
        .load      (state_d == SEND),
        .slot_data (slot_d),
        .beat      (b_d),
        .beat_data (mem_data)
    );

    assign busy       = busy_q;
    assign done       = done_q;
    assign ob_idx     = idx_q;
    assign ob_read_en = rd_q;
    assign mem_valid  = valid_q;
    assign mem_addr   = addr_q;
    assign mem_last   = last_q;

endmodule

// File: tb/tb_output_drain.sv
// tb/tb_output_drain.sv - randomized self-checking bench for output_drain against a slot/beat model
module tb_output_drain;
    import pdn_drain_pkg::*;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          start;
    logic [ADDR_W-1:0]             base_addr;
    logic [IDX_W-1:0]              slot_first;
    logic [CNT_W-1:0]              slot_count;
    logic                          busy;
    logic                          done;
    logic [IDX_W-1:0]              ob_idx;
    logic                          ob_read_en;
    logic [LANES*DATA_W-1:0]       ob_out;
    logic                          mem_valid;
    logic                          mem_ready;
    logic [ADDR_W-1:0]             mem_addr;
    logic [BEAT_LANES*DATA_W-1:0]  mem_data;
    logic                          mem_last;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] ob_mem [SLOTS][LANES];

    logic [IDX_W-1:0]             exp_idx[$],  obs_idx[$];
    logic [ADDR_W-1:0]            exp_addr[$], obs_addr[$];
    logic [BEAT_LANES*DATA_W-1:0] exp_data[$], obs_data[$];
    logic                         exp_last[$], obs_last[$];
    int done_cycle, done_count, stab_viol, stall_cycles, rd_cycles, valid_cycles;

    always #5 clk = ~clk;

    output_drain dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .slot_first (slot_first),
        .slot_count (slot_count),
        .busy       (busy),
        .done       (done),
        .ob_idx     (ob_idx),
        .ob_read_en (ob_read_en),
        .ob_out     (ob_out),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_last   (mem_last)
    );

    // Output buffer model: one-cycle read latency.
    always @(posedge clk) begin
        if (ob_read_en === 1'b1) begin
            for (int j = 0; j < LANES; j++) ob_out[j*DATA_W +: DATA_W] <= ob_mem[ob_idx][j];
        end
    end

    task automatic fill_mem(input bit ramp);
        for (int s = 0; s < SLOTS; s++)
            for (int l = 0; l < LANES; l++)
                ob_mem[s][l] = ramp ? DATA_W'(s * LANES + l) : $urandom;
    endtask

    task automatic build_expected(input logic [ADDR_W-1:0] b, input int f, input int cnt);
        logic [BEAT_LANES*DATA_W-1:0] d;
        exp_idx.delete(); exp_addr.delete(); exp_data.delete(); exp_last.delete();
        for (int s = 0; s < cnt; s++) begin
            int sl;
            sl = (f + s) % SLOTS;
            exp_idx.push_back(IDX_W'(sl));
            for (int k = 0; k < BEATS_PER_SLOT; k++) begin
                for (int j = 0; j < BEAT_LANES; j++) d[j*DATA_W +: DATA_W] = ob_mem[sl][k*BEAT_LANES + j];
                exp_addr.push_back(b + ADDR_W'((s * LANES + k * BEAT_LANES) * 4));
                exp_data.push_back(d);
                exp_last.push_back(k == BEATS_PER_SLOT - 1);
            end
        end
    endtask

    task automatic run_cmd(input logic [ADDR_W-1:0] b, input int f, input int cnt,
                           input int mode, input int restart_c, input int max_c);
        logic                         prev_stall;
        logic [ADDR_W-1:0]            p_addr;
        logic [BEAT_LANES*DATA_W-1:0] p_data;
        logic                         p_last;
        obs_idx.delete(); obs_addr.delete(); obs_data.delete(); obs_last.delete();
        done_cycle = -1; done_count = 0; stab_viol = 0; stall_cycles = 0;
        rd_cycles = 0; valid_cycles = 0; prev_stall = 1'b0;
        p_addr = '0; p_data = '0; p_last = 1'b0;
        @(negedge clk);
        start = 1'b1; base_addr = b; slot_first = IDX_W'(f); slot_count = CNT_W'(cnt); mem_ready = 1'b0;
        for (int c = 1; c <= max_c; c++) begin
            @(negedge clk);
            start      = (c == restart_c);
            base_addr  = $urandom;
            slot_first = IDX_W'($urandom);
            slot_count = start ? CNT_W'(3) : CNT_W'($urandom);
            case (mode)
                0:       mem_ready = 1'b1;
                1:       mem_ready = (c % 3 == 0);
                default: mem_ready = 1'($urandom_range(0, 1));
            endcase
            if (prev_stall && (mem_valid !== 1'b1 || mem_addr !== p_addr ||
                               mem_data !== p_data || mem_last !== p_last)) stab_viol++;
            if (ob_read_en === 1'b1) begin
                rd_cycles++;
                obs_idx.push_back(ob_idx);
            end
            if (mem_valid === 1'b1) valid_cycles++;
            if (mem_valid === 1'b1 && mem_ready) begin
                obs_addr.push_back(mem_addr);
                obs_data.push_back(mem_data);
                obs_last.push_back(mem_last);
            end
            prev_stall = (mem_valid === 1'b1) && !mem_ready;
            if (prev_stall) stall_cycles++;
            p_addr = mem_addr; p_data = mem_data; p_last = mem_last;
            if (done === 1'b1) begin
                done_count++;
                if (done_cycle < 0) done_cycle = c;
            end
            if (done_cycle >= 0 && c >= done_cycle + 3) break;
        end
        start = 1'b0;
    endtask

    task automatic test_transfer(input string tag, input logic [ADDR_W-1:0] b, input int f,
                                 input int cnt, input int mode, input int restart_c, input int exp_done);
        build_expected(b, f, cnt);
        run_cmd(b, f, cnt, mode, restart_c, 200 * cnt + 50);
        checks++;
        if (obs_addr.size() != exp_addr.size()) begin
            errors++;
            $display("FAIL %s beat_count: got %0d want %0d", tag, obs_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            checks++;
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin
                errors++;
                $display("FAIL %s beat%0d: got addr=%h last=%b data=%h want addr=%h last=%b data=%h",
                         tag, i, obs_addr[i], obs_last[i], obs_data[i], exp_addr[i], exp_last[i], exp_data[i]);
            end
        end
        checks++;
        if (obs_idx.size() != exp_idx.size()) begin
            errors++;
            $display("FAIL %s read_count: got %0d want %0d", tag, obs_idx.size(), exp_idx.size());
        end
        for (int i = 0; i < exp_idx.size() && i < obs_idx.size(); i++) begin
            checks++;
            if (obs_idx[i] !== exp_idx[i]) begin
                errors++;
                $display("FAIL %s ob_idx%0d: got %0d want %0d", tag, i, obs_idx[i], exp_idx[i]);
            end
        end
        checks++;
        if (stab_viol != 0) begin
            errors++;
            $display("FAIL %s stall_stability: got %0d changes want 0", tag, stab_viol);
        end
        checks++;
        if (done_count != 1) begin
            errors++;
            $display("FAIL %s done_pulses: got %0d want 1", tag, done_count);
        end
        checks++;
        if (done_cycle != 34 * cnt + 1 + stall_cycles) begin
            errors++;
            $display("FAIL %s done_vs_stalls: got %0d want %0d", tag, done_cycle, 34 * cnt + 1 + stall_cycles);
        end
        if (exp_done >= 0) begin
            checks++;
            if (done_cycle != exp_done) begin
                errors++;
                $display("FAIL %s done_cycle: got %0d want %0d", tag, done_cycle, exp_done);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, ob_read_en, mem_valid, mem_last} !== 5'b0 || ob_idx !== '0 ||
            mem_addr !== '0 || mem_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ctl=%b idx=%0d addr=%h want all zero",
                     {busy, done, ob_read_en, mem_valid, mem_last}, ob_idx, mem_addr);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_single_slot;
        test_transfer("single", 32'h1000, 0, 1, 0, 0, 35);
    endtask

    task automatic test_backpressure;
        test_transfer("backpressure", 32'h1000, 0, 1, 1, 0, 3 + 3 * (BEATS_PER_SLOT - 1) + 1);
        checks++;
        if (stall_cycles != 2 * (BEATS_PER_SLOT - 1)) begin
            errors++;
            $display("FAIL backpressure stalls: got %0d want %0d", stall_cycles, 2 * (BEATS_PER_SLOT - 1));
        end
    endtask

    task automatic test_wrap;
        test_transfer("wrap", 32'h0, 14, 4, 0, 0, 137);
    endtask

    task automatic test_zero_count;
        run_cmd(32'h1234, 5, 0, 0, 0, 50);
        checks++;
        if (done_cycle != 1 || done_count != 1) begin
            errors++;
            $display("FAIL zero_done: got cycle=%0d pulses=%0d want cycle=1 pulses=1", done_cycle, done_count);
        end
        checks++;
        if (rd_cycles != 0 || valid_cycles != 0) begin
            errors++;
            $display("FAIL zero_activity: got reads=%0d valids=%0d want 0 0", rd_cycles, valid_cycles);
        end
    endtask

    task automatic test_reset_mid_send;
        @(negedge clk);
        start = 1'b1; base_addr = 32'h1000; slot_first = '0; slot_count = CNT_W'(1); mem_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        checks++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h1000 + 32'd320) begin
            errors++;
            $display("FAIL midsend_beat10: got valid=%b addr=%h want 1 %h", mem_valid, mem_addr, 32'h1140);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({busy, done, ob_read_en, mem_valid, mem_last} !== 5'b0 || ob_idx !== '0 ||
            mem_addr !== '0 || mem_data !== '0) begin
            errors++;
            $display("FAIL midsend_async_reset: got ctl=%b idx=%0d addr=%h want all zero",
                     {busy, done, ob_read_en, mem_valid, mem_last}, ob_idx, mem_addr);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        fill_mem(1'b0);
        test_transfer("post_reset", 32'h2000, 3, 1, 0, 0, 35);
    endtask

    task automatic test_start_while_busy;
        test_transfer("start_busy", 32'h8000, 7, 2, 0, 20, 69);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_busy idle_after: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_random;
        fill_mem(1'b0);
        test_transfer("rand_addrwrap", 32'hFFFF_FF00, 15, 2, 2, 0, -1);
        for (int t = 0; t < 3; t++) begin
            fill_mem(1'b0);
            test_transfer("rand", $urandom, $urandom_range(0, SLOTS - 1), $urandom_range(1, 3), 2, 0, -1);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; start = 1'b0; base_addr = '0; slot_first = '0; slot_count = '0;
        mem_ready = 1'b0; ob_out = '0;
        fill_mem(1'b1);
        test_reset;
        test_single_slot;
        test_backpressure;
        fill_mem(1'b0);
        test_wrap;
        test_zero_count;
        test_reset_mid_send;
        test_start_while_busy;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
